// File: rtl/data_mem_arbiter.sv
// Round-robin sequencer that shares the single-ported data memory between the core
// data port (m0) and the loader/DMA port (m1), with core stall and acknowledge timeout.
module data_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_rd,
  input  logic                  m0_wr,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_stall,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_done,
  output logic                  m1_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  typedef enum logic [2:0] {IDLE, BUSY0, DONE0, BUSY1, DONE1} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t                r_state;
  logic                  r_last_gnt;
  logic [7:0]            r_cnt;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_m0_rdata;
  logic [DATA_WIDTH-1:0] r_m1_rdata;
  logic                  r_m0_err;
  logic                  r_m1_err;
  logic                  r_m1_gnt;
  logic                  r_m1_done;

  logic w_req0;
  logic w_req1;
  logic w_pick1;
  logic w_busy1;
  logic w_finish;

  assign w_req0   = m0_rd | m0_wr;
  assign w_req1   = m1_req;
  // On a tie the master that did not win the previous transfer is granted.
  assign w_pick1  = w_req1 & (~w_req0 | ~r_last_gnt);
  assign w_busy1  = (r_state == BUSY1);
  // An acknowledge in the final allowed cycle counts as a normal completion.
  assign w_finish = mem_ack | (r_cnt == TO_LAST);

  // NOTE: all state updates use non-blocking assignments so every register samples
  // the pre-edge values and the block order cannot change behaviour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_last_gnt  <= 1'b1;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
      r_m0_err    <= 1'b0;
      r_m1_err    <= 1'b0;
      r_m1_gnt    <= 1'b0;
      r_m1_done   <= 1'b0;
    end else begin
      r_m1_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req0 | w_req1) begin
            r_mem_req <= 1'b1;
            r_cnt     <= '0;
            if (w_pick1) begin
              r_state     <= BUSY1;
              r_m1_gnt    <= 1'b1;
              r_mem_we    <= m1_we;
              r_mem_addr  <= m1_addr;
              r_mem_wdata <= m1_wdata;
            end else begin
              r_state     <= BUSY0;
              r_mem_we    <= m0_wr;
              r_mem_addr  <= m0_addr;
              r_mem_wdata <= m0_wdata;
            end
          end
        end
        BUSY0, BUSY1: begin
          if (w_finish) begin
            r_mem_req  <= 1'b0;
            r_m1_gnt   <= 1'b0;
            r_last_gnt <= w_busy1;
            r_m1_done  <= w_busy1;
            r_state    <= w_busy1 ? DONE1 : DONE0;
            if (w_busy1) begin
              r_m1_err <= ~mem_ack;
              if (!mem_ack)      r_m1_rdata <= '0;
              else if (!r_mem_we) r_m1_rdata <= mem_rdata;
            end else begin
              r_m0_err <= ~mem_ack;
              if (!mem_ack)      r_m0_rdata <= '0;
              else if (!r_mem_we) r_m0_rdata <= mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m0_stall  = w_req0 & (r_state != DONE0);
  assign m0_rdata  = r_m0_rdata;
  assign m0_err    = r_m0_err;
  assign m1_gnt    = r_m1_gnt;
  assign m1_rdata  = r_m1_rdata;
  assign m1_done   = r_m1_done;
  assign m1_err    = r_m1_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: cycle table, directed corner sequences and a random
// run checked against a transaction-schedule model of the arbiter.
module tb_data_mem_arbiter;

  localparam int TO = 4;
  localparam logic [31:0] A0 = 32'h1001_0004;
  localparam logic [31:0] A1 = 32'h1001_0000;
  localparam logic [31:0] W0 = 32'hAAAA_0000;
  localparam logic [31:0] W1 = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_rd, m0_wr, m1_req, m1_we, mem_ack;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
  logic        m0_stall, m0_err, m1_gnt, m1_done, m1_err, mem_req, mem_we;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] ref_mem [8];
  logic [31:0] env_mem [8];

  data_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_stall(m0_stall), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rd, wr, req1, we1, ack;
    logic [31:0] rdata;
    logic        e_stall, e_req, e_we, e_gnt, e_done;
    logic [31:0] e_addr, e_wdata, e_r0, e_r1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rd, logic wr, logic req1, logic we1, logic ack,
                              logic [31:0] rdata, logic e_stall, logic e_req, logic e_we,
                              logic e_gnt, logic e_done, logic [31:0] e_addr,
                              logic [31:0] e_wdata, logic [31:0] e_r0, logic [31:0] e_r1);
    vec_t v;
    v.rd = rd; v.wr = wr; v.req1 = req1; v.we1 = we1; v.ack = ack; v.rdata = rdata;
    v.e_stall = e_stall; v.e_req = e_req; v.e_we = e_we; v.e_gnt = e_gnt; v.e_done = e_done;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_r0 = e_r0; v.e_r1 = e_r1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m0_rd = 1'b1; m0_wr = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
    m0_addr = '0; m0_wdata = '0; m1_addr = '0; m1_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("rst mem_req", mem_req, 1'b0);
    check1("rst mem_we", mem_we, 1'b0);
    check1("rst m1_gnt", m1_gnt, 1'b0);
    check1("rst m1_done", m1_done, 1'b0);
    check1("rst m0_err", m0_err, 1'b0);
    check1("rst m1_err", m1_err, 1'b0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    check("rst m0_rdata", m0_rdata, 32'h0);
    check("rst m1_rdata", m1_rdata, 32'h0);
    check1("rst stall follows req0", m0_stall, 1'b1);
    m0_rd = 1'b0;
    #1;
    check1("rst stall idle", m0_stall, 1'b0);
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic run_table();
    m0_addr = A0; m0_wdata = W0; m1_addr = A1; m1_wdata = W1;
    foreach (tbl[i]) begin
      m0_rd = tbl[i].rd; m0_wr = tbl[i].wr; m1_req = tbl[i].req1; m1_we = tbl[i].we1;
      mem_ack = tbl[i].ack; mem_rdata = tbl[i].rdata;
      @(negedge clk);
      check1($sformatf("row%0d m0_stall", i), m0_stall, tbl[i].e_stall);
      check1($sformatf("row%0d mem_req", i), mem_req, tbl[i].e_req);
      check1($sformatf("row%0d m1_gnt", i), m1_gnt, tbl[i].e_gnt);
      check1($sformatf("row%0d m1_done", i), m1_done, tbl[i].e_done);
      check($sformatf("row%0d m0_rdata", i), m0_rdata, tbl[i].e_r0);
      check($sformatf("row%0d m1_rdata", i), m1_rdata, tbl[i].e_r1);
      check1($sformatf("row%0d m0_err", i), m0_err, 1'b0);
      check1($sformatf("row%0d m1_err", i), m1_err, 1'b0);
      if (tbl[i].e_req) begin
        check1($sformatf("row%0d mem_we", i), mem_we, tbl[i].e_we);
        check($sformatf("row%0d mem_addr", i), mem_addr, tbl[i].e_addr);
        if (tbl[i].e_we) check($sformatf("row%0d mem_wdata", i), mem_wdata, tbl[i].e_wdata);
      end
      next_cycle();
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_timeout();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h1001_0008; mem_ack = 1'b0;
    @(negedge clk);
    check1("to idle m1_gnt", m1_gnt, 1'b0);
    next_cycle();
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      check1($sformatf("to busy%0d mem_req", i), mem_req, 1'b1);
      check1($sformatf("to busy%0d m1_gnt", i), m1_gnt, 1'b1);
      next_cycle();
    end
    @(negedge clk);
    check1("to done mem_req", mem_req, 1'b0);
    check1("to done m1_done", m1_done, 1'b1);
    check1("to done m1_err", m1_err, 1'b1);
    check("to done m1_rdata", m1_rdata, 32'h0);
    next_cycle();
    m1_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1($sformatf("to stray%0d mem_req", i), mem_req, 1'b0);
      check1($sformatf("to stray%0d m1_done", i), m1_done, 1'b0);
      check("to stray m1_rdata", m1_rdata, 32'h0);
      next_cycle();
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    m0_rd = 1'b1; m0_wr = 1'b0; m0_addr = A0; mem_ack = 1'b0;
    next_cycle();
    @(negedge clk);
    check1("rm busy mem_req", mem_req, 1'b1);
    rst = 1'b0;
    #1;
    check1("rm async mem_req", mem_req, 1'b0);
    check1("rm stall in reset", m0_stall, 1'b1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check1("rm idle mem_req", mem_req, 1'b0);
    next_cycle();
    mem_ack = 1'b1; mem_rdata = 32'h7777_0007;
    @(negedge clk);
    check1("rm busy2 mem_req", mem_req, 1'b1);
    check("rm busy2 mem_addr", mem_addr, A0);
    check1("rm busy2 stall", m0_stall, 1'b1);
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    check1("rm done stall", m0_stall, 1'b0);
    check("rm done m0_rdata", m0_rdata, 32'h7777_0007);
    check1("rm done m0_err", m0_err, 1'b0);
    next_cycle();
    m0_rd = 1'b0;
  endtask

  task automatic test_m1_release();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h1001_000C; mem_ack = 1'b0;
    next_cycle();
    @(negedge clk);
    check1("rel busy1 m1_gnt", m1_gnt, 1'b1);
    next_cycle();
    m1_req = 1'b0;
    @(negedge clk);
    check1("rel busy2 m1_gnt", m1_gnt, 1'b1);
    check1("rel busy2 mem_req", mem_req, 1'b1);
    next_cycle();
    mem_ack = 1'b1; mem_rdata = 32'h6666_0006;
    @(negedge clk);
    check1("rel busy3 mem_req", mem_req, 1'b1);
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    check1("rel done m1_done", m1_done, 1'b1);
    check("rel done m1_rdata", m1_rdata, 32'h6666_0006);
    check1("rel done m1_err", m1_err, 1'b0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check1($sformatf("rel after%0d mem_req", i), mem_req, 1'b0);
      check1($sformatf("rel after%0d m1_done", i), m1_done, 1'b0);
      next_cycle();
    end
  endtask

  // The model plans each transfer as a time window: grant cycle, busy cycles
  // (memory wait + 1, capped at TO) and a single done cycle.
  task automatic run_random(input int ncyc);
    bit active, last, p0, p1, busy, dn, err;
    int owner, bstart, dcyc, lat, op, idx;
    logic t_we;
    logic [31:0] t_addr, t_wdata, e_r0, e_r1;
    active = 0; last = 1; p0 = 0; p1 = 0; err = 0;
    owner = 0; bstart = 0; dcyc = 0; lat = 0; op = 0; idx = 0;
    t_we = 0; t_addr = '0; t_wdata = '0; e_r0 = '0; e_r1 = '0;
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = $urandom;
      env_mem[i] = ref_mem[i];
    end
    for (int c = 0; c < ncyc; c++) begin
      if (active && c == dcyc + 1) begin
        active = 0;
        if (owner == 0) p0 = 0; else p1 = 0;
      end
      if (!p0) begin
        if ($urandom_range(2) == 0) begin
          op = int'($urandom_range(3));
          m0_rd = (op <= 1) || (op == 3);
          m0_wr = (op >= 2);
          m0_addr = 32'h1001_0000 + 32'(4 * $urandom_range(7));
          m0_wdata = $urandom;
          p0 = 1;
        end else begin
          m0_rd = 1'b0; m0_wr = 1'b0;
        end
      end
      if (!p1) begin
        if ($urandom_range(2) == 0) begin
          m1_req = 1'b1;
          m1_we = 1'($urandom_range(1));
          m1_addr = 32'h1001_0000 + 32'(4 * $urandom_range(7));
          m1_wdata = $urandom;
          p1 = 1;
        end else begin
          m1_req = 1'b0;
        end
      end else if (active && owner == 1 && c >= bstart && c < dcyc && $urandom_range(3) == 0) begin
        m1_req = 1'b0;
      end
      if (!active && (m0_rd || m0_wr || m1_req)) begin
        if ((m0_rd || m0_wr) && m1_req) owner = last ? 0 : 1;
        else owner = m1_req ? 1 : 0;
        last = (owner == 1);
        active = 1;
        bstart = c + 1;
        lat = int'($urandom_range(5));
        dcyc = bstart + ((lat < TO) ? lat + 1 : TO);
        t_we = (owner == 1) ? m1_we : m0_wr;
        t_addr = (owner == 1) ? m1_addr : m0_addr;
        t_wdata = (owner == 1) ? m1_wdata : m0_wdata;
      end
      busy = active && c >= bstart && c < dcyc;
      dn = active && c == dcyc;
      if (busy) begin
        mem_ack = (c - bstart == lat);
        mem_rdata = env_mem[mem_addr[4:2]];
        if (mem_ack && mem_we) env_mem[mem_addr[4:2]] = mem_wdata;
      end else begin
        mem_ack = ($urandom_range(3) == 0);
        mem_rdata = $urandom;
      end
      if (dn) begin
        idx = int'(t_addr[4:2]);
        err = (lat >= TO);
        if (owner == 0) begin
          if (err) e_r0 = '0; else if (!t_we) e_r0 = ref_mem[idx];
        end else begin
          if (err) e_r1 = '0; else if (!t_we) e_r1 = ref_mem[idx];
        end
        if (!err && t_we) ref_mem[idx] = t_wdata;
      end
      @(negedge clk);
      check1("rnd mem_req", mem_req, busy);
      check1("rnd m1_gnt", m1_gnt, busy && owner == 1);
      check1("rnd m1_done", m1_done, dn && owner == 1);
      check1("rnd m0_stall", m0_stall, (m0_rd | m0_wr) && !(dn && owner == 0));
      check("rnd m0_rdata", m0_rdata, e_r0);
      check("rnd m1_rdata", m1_rdata, e_r1);
      if (busy) begin
        check("rnd mem_addr", mem_addr, t_addr);
        check1("rnd mem_we", mem_we, t_we);
        if (t_we) check("rnd mem_wdata", mem_wdata, t_wdata);
      end
      if (dn && owner == 0) check1("rnd m0_err", m0_err, err);
      if (dn && owner == 1) check1("rnd m1_err", m1_err, err);
      next_cycle();
    end
    m0_rd = 1'b0; m0_wr = 1'b0; m1_req = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    // Two collisions, then core load with zero wait, then loader write with 3 wait cycles.
    tbl.push_back(mk(0,1,1,0,0,32'h0,          1,0,0,0,0, 32'h0,32'h0, 32'h0,32'h0));
    tbl.push_back(mk(0,1,1,0,1,32'h0,          1,1,1,0,0, A0,W0,       32'h0,32'h0));
    tbl.push_back(mk(0,1,1,0,0,32'h0,          0,0,0,0,0, 32'h0,32'h0, 32'h0,32'h0));
    tbl.push_back(mk(0,0,1,0,1,32'hBAD0_0000,  0,0,0,0,0, 32'h0,32'h0, 32'h0,32'h0));
    tbl.push_back(mk(0,0,1,0,1,32'h5555_0001,  0,1,0,1,0, A1,32'h0,    32'h0,32'h0));
    tbl.push_back(mk(0,0,1,0,0,32'h0,          0,0,0,0,1, 32'h0,32'h0, 32'h0,32'h5555_0001));
    tbl.push_back(mk(0,1,1,0,0,32'h0,          1,0,0,0,0, 32'h0,32'h0, 32'h0,32'h5555_0001));
    tbl.push_back(mk(0,1,1,0,1,32'h0,          1,1,1,0,0, A0,W0,       32'h0,32'h5555_0001));
    tbl.push_back(mk(0,1,1,0,0,32'h0,          0,0,0,0,0, 32'h0,32'h0, 32'h0,32'h5555_0001));
    tbl.push_back(mk(0,0,1,0,0,32'h0,          0,0,0,0,0, 32'h0,32'h0, 32'h0,32'h5555_0001));
    tbl.push_back(mk(0,0,1,0,1,32'h5555_0002,  0,1,0,1,0, A1,32'h0,    32'h0,32'h5555_0001));
    tbl.push_back(mk(0,0,1,0,0,32'h0,          0,0,0,0,1, 32'h0,32'h0, 32'h0,32'h5555_0002));
    tbl.push_back(mk(1,0,0,0,0,32'h0,          1,0,0,0,0, 32'h0,32'h0, 32'h0,32'h5555_0002));
    tbl.push_back(mk(1,0,0,0,1,32'hCAFE_0001,  1,1,0,0,0, A0,32'h0,    32'h0,32'h5555_0002));
    tbl.push_back(mk(1,0,0,0,0,32'h0,          0,0,0,0,0, 32'h0,32'h0, 32'hCAFE_0001,32'h5555_0002));
    tbl.push_back(mk(0,0,0,0,0,32'h0,          0,0,0,0,0, 32'h0,32'h0, 32'hCAFE_0001,32'h5555_0002));
    tbl.push_back(mk(0,0,1,1,0,32'h0,          0,0,0,0,0, 32'h0,32'h0, 32'hCAFE_0001,32'h5555_0002));
    tbl.push_back(mk(0,0,1,1,0,32'h0,          0,1,1,1,0, A1,W1,       32'hCAFE_0001,32'h5555_0002));
    tbl.push_back(mk(0,0,1,1,0,32'h0,          0,1,1,1,0, A1,W1,       32'hCAFE_0001,32'h5555_0002));
    tbl.push_back(mk(0,0,1,1,0,32'h0,          0,1,1,1,0, A1,W1,       32'hCAFE_0001,32'h5555_0002));
    tbl.push_back(mk(0,0,1,1,1,32'h0,          0,1,1,1,0, A1,W1,       32'hCAFE_0001,32'h5555_0002));
    tbl.push_back(mk(0,0,1,1,0,32'h0,          0,0,0,0,1, 32'h0,32'h0, 32'hCAFE_0001,32'h5555_0002));
    tbl.push_back(mk(0,0,0,0,0,32'h0,          0,0,0,0,0, 32'h0,32'h0, 32'hCAFE_0001,32'h5555_0002));

    do_reset();
    run_table();
    test_timeout();
    test_reset_mid();
    test_m1_release();
    do_reset();
    run_random(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
